bus_xfer_ctrl: RTL and testbench

Sequencer that performs register-to-register transfers over the shared 16-bit datapath bus. It is the reader/driver counterpart of the bus-attached registers. It pulses a source register's LDBUS strobe, captures that register's BOUT, then drives BIN and pulses the destination's WR strobe. It also issues single-cycle INC commands and sits between the instruction control unit and the register file.

---
 rtl/bus_xfer_ctrl.sv | 124 ++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register transfer sequencer over the shared datapath bus.
// Moves read a source via LDBUS/BOUT, then write the destination via BIN/WR; increments pulse INC.
module bus_xfer_ctrl #(
    parameter int unsigned N_REGS = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       REQ,
    input  logic                       OP,
    input  logic [ADDR_W-1:0]          SRC,
    input  logic [ADDR_W-1:0]          DST,
    input  logic [N_REGS*DATA_W-1:0]   BUS_RD,
    output logic [DATA_W-1:0]          BIN,
    output logic [N_REGS-1:0]          LDBUS,
    output logic [N_REGS-1:0]          WR,
    output logic [N_REGS-1:0]          INC,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       ERR
);

    typedef enum logic [2:0] {IDLE, LOAD, CAPT, WRITE, INCR, FIN} state_t;

    localparam logic [N_REGS-1:0] ONE_HOT0 = N_REGS'(1);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [N_REGS-1:0]   ldbus_d, wr_d, inc_d;
    logic                busy_d, done_d, err_d;
    logic                src_ok, dst_ok;

    assign src_ok = (32'(SRC) < N_REGS);
    assign dst_ok = (32'(DST) < N_REGS);

    // State, latched indices, captured data and registered strobes.
    always_ff @(posedge clk) begin
        if (RST) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            data_q <= '0;
            LDBUS  <= '0;
            WR     <= '0;
            INC    <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= state_d;
            src_q  <= src_d;
            dst_q  <= dst_d;
            data_q <= data_d;
            LDBUS  <= ldbus_d;
            WR     <= wr_d;
            INC    <= inc_d;
            BUSY   <= busy_d;
            DONE   <= done_d;
            ERR    <= err_d;
        end
    end

    // Next state plus next strobe values decoded from the state being entered.
    always_comb begin
        state_d = state;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        ldbus_d = '0;
        wr_d    = '0;
        inc_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state)
            IDLE: begin
                if (REQ) begin
                    if (!OP && src_ok && dst_ok) begin
                        src_d   = SRC;
                        dst_d   = DST;
                        state_d = LOAD;
                    end else if (OP && dst_ok) begin
                        dst_d   = DST;
                        state_d = INCR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD:  state_d = CAPT;
            CAPT: begin
                state_d = WRITE;
                data_d  = BUS_RD[32'(src_q)*DATA_W +: DATA_W];
            end
            WRITE: state_d = FIN;
            INCR:  state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            LOAD, CAPT: begin
                ldbus_d = ONE_HOT0 << src_d;
                busy_d  = 1'b1;
            end
            WRITE: begin
                wr_d   = ONE_HOT0 << dst_d;
                busy_d = 1'b1;
            end
            INCR: begin
                inc_d  = ONE_HOT0 << dst_d;
                busy_d = 1'b1;
            end
            FIN:     done_d = 1'b1;
            default: ;
        endcase
    end

    assign BIN = data_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with a small model of the bus-attached register file.
module tb_bus_xfer_ctrl;

    localparam int unsigned N_REGS = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    logic                     clk;
    logic                     RST;
    logic                     REQ;
    logic                     OP;
    logic [ADDR_W-1:0]        SRC;
    logic [ADDR_W-1:0]        DST;
    logic [N_REGS*DATA_W-1:0] BUS_RD;
    logic [DATA_W-1:0]        BIN;
    logic [N_REGS-1:0]        LDBUS;
    logic [N_REGS-1:0]        WR;
    logic [N_REGS-1:0]        INC;
    logic                     BUSY;
    logic                     DONE;
    logic                     ERR;

    logic [DATA_W-1:0] regs [N_REGS];
    logic [26:0]       obs;
    int                n_chk  = 0;
    int                n_fail = 0;

    bus_xfer_ctrl #(.N_REGS(N_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .RST(RST), .REQ(REQ), .OP(OP), .SRC(SRC), .DST(DST),
        .BUS_RD(BUS_RD), .BIN(BIN), .LDBUS(LDBUS), .WR(WR), .INC(INC),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed strobe/status vector: {LDBUS, WR, INC, BUSY, DONE, ERR}
    assign obs = {LDBUS, WR, INC, BUSY, DONE, ERR};

    always_comb begin
        for (int i = 0; i < N_REGS; i++) BUS_RD[i*DATA_W +: DATA_W] = regs[i];
    end

    // Register file model reacting to write and increment strobes.
    always @(posedge clk) begin
        for (int i = 0; i < N_REGS; i++) begin
            if (WR[i])  regs[i] <= BIN;
            if (INC[i]) regs[i] <= regs[i] + 16'h0001;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic [3:0] s, input logic [3:0] d);
        REQ = 1'b1; OP = op; SRC = s; DST = d;
        tick();
        REQ = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = 1'b0; OP = 1'b0; SRC = '0; DST = '0;
        tick(); tick();
        n_chk++;
        if (obs !== 27'd0) begin n_fail++; $display("FAIL reset_strobes: got %h want %h", obs, 27'd0); end
        n_chk++;
        if (BIN !== 16'h0000) begin n_fail++; $display("FAIL reset_bin: got %h want %h", BIN, 16'h0000); end
        RST = 1'b0;
        tick();
        n_chk++;
        if (obs !== 27'd0) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs, 27'd0); end
    endtask

    task automatic test_move();
        regs[3] = 16'hA5C3; regs[5] = 16'h0000;
        issue(1'b0, 4'd3, 4'd5);
        n_chk++;
        if (obs !== {8'h08, 8'h00, 8'h00, 3'b100}) begin n_fail++; $display("FAIL move_load: got %h want %h", obs, {8'h08, 8'h00, 8'h00, 3'b100}); end
        tick();
        n_chk++;
        if (obs !== {8'h08, 8'h00, 8'h00, 3'b100}) begin n_fail++; $display("FAIL move_capt: got %h want %h", obs, {8'h08, 8'h00, 8'h00, 3'b100}); end
        tick();
        n_chk++;
        if (obs !== {8'h00, 8'h20, 8'h00, 3'b100}) begin n_fail++; $display("FAIL move_write: got %h want %h", obs, {8'h00, 8'h20, 8'h00, 3'b100}); end
        n_chk++;
        if (BIN !== 16'hA5C3) begin n_fail++; $display("FAIL move_bin: got %h want %h", BIN, 16'hA5C3); end
        tick();
        n_chk++;
        if (obs !== {8'h00, 8'h00, 8'h00, 3'b010}) begin n_fail++; $display("FAIL move_done: got %h want %h", obs, {8'h00, 8'h00, 8'h00, 3'b010}); end
        n_chk++;
        if (regs[5] !== 16'hA5C3) begin n_fail++; $display("FAIL move_dest: got %h want %h", regs[5], 16'hA5C3); end
        tick();
        n_chk++;
        if (obs !== 27'd0) begin n_fail++; $display("FAIL move_idle: got %h want %h", obs, 27'd0); end
    endtask

    task automatic test_increment();
        regs[2] = 16'hFFFF;
        issue(1'b1, 4'd0, 4'd2);
        n_chk++;
        if (obs !== {8'h00, 8'h00, 8'h04, 3'b100}) begin n_fail++; $display("FAIL inc_strobe: got %h want %h", obs, {8'h00, 8'h00, 8'h04, 3'b100}); end
        tick();
        n_chk++;
        if (obs !== {8'h00, 8'h00, 8'h00, 3'b010}) begin n_fail++; $display("FAIL inc_done: got %h want %h", obs, {8'h00, 8'h00, 8'h00, 3'b010}); end
        n_chk++;
        if (regs[2] !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap: got %h want %h", regs[2], 16'h0000); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [26:0] exp;
        regs[1] = 16'h1234;
        REQ = 1'b1; OP = 1'b0; SRC = 4'd1; DST = 4'd1;
        tick();
        for (int s = 1; s <= 10; s++) begin
            case ((s - 1) % 5)
                0, 1:    exp = {8'h02, 8'h00, 8'h00, 3'b100};
                2:       exp = {8'h00, 8'h02, 8'h00, 3'b100};
                3:       exp = {8'h00, 8'h00, 8'h00, 3'b010};
                default: exp = 27'd0;
            endcase
            n_chk++;
            if (obs !== exp) begin n_fail++; $display("FAIL b2b_cycle%0d: got %h want %h", s, obs, exp); end
            if ((s - 1) % 5 == 2) begin
                n_chk++;
                if (BIN !== 16'h1234) begin n_fail++; $display("FAIL b2b_bin%0d: got %h want %h", s, BIN, 16'h1234); end
            end
            if (s == 10) REQ = 1'b0;
            tick();
        end
        n_chk++;
        if (obs !== 27'd0) begin n_fail++; $display("FAIL b2b_quiet: got %h want %h", obs, 27'd0); end
        n_chk++;
        if (regs[1] !== 16'h1234) begin n_fail++; $display("FAIL b2b_self: got %h want %h", regs[1], 16'h1234); end
    endtask

    task automatic test_error();
        REQ = 1'b1; OP = 1'b0; SRC = 4'd9; DST = 4'd0;
        tick();
        n_chk++;
        if (obs !== {8'h00, 8'h00, 8'h00, 3'b001}) begin n_fail++; $display("FAIL err_src: got %h want %h", obs, {8'h00, 8'h00, 8'h00, 3'b001}); end
        REQ = 1'b0;
        tick();
        n_chk++;
        if (obs !== 27'd0) begin n_fail++; $display("FAIL err_clear: got %h want %h", obs, 27'd0); end
        REQ = 1'b1; OP = 1'b1; SRC = 4'd0; DST = 4'd8;
        tick();
        n_chk++;
        if (obs !== {8'h00, 8'h00, 8'h00, 3'b001}) begin n_fail++; $display("FAIL err_dst: got %h want %h", obs, {8'h00, 8'h00, 8'h00, 3'b001}); end
        // a valid request immediately after a rejection is accepted at once
        regs[0] = 16'h0010;
        DST = 4'd0;
        tick();
        REQ = 1'b0;
        n_chk++;
        if (obs !== {8'h00, 8'h00, 8'h01, 3'b100}) begin n_fail++; $display("FAIL err_recover: got %h want %h", obs, {8'h00, 8'h00, 8'h01, 3'b100}); end
        tick(); tick();
        n_chk++;
        if (regs[0] !== 16'h0011) begin n_fail++; $display("FAIL err_recover_val: got %h want %h", regs[0], 16'h0011); end
    endtask

    task automatic test_ignore_req();
        regs[3] = 16'h5A5A; regs[4] = 16'h7777; regs[5] = 16'h0000; regs[6] = 16'h0000;
        issue(1'b0, 4'd3, 4'd5);
        REQ = 1'b1; OP = 1'b0; SRC = 4'd4; DST = 4'd6;
        n_chk++;
        if (obs !== {8'h08, 8'h00, 8'h00, 3'b100}) begin n_fail++; $display("FAIL ign_load: got %h want %h", obs, {8'h08, 8'h00, 8'h00, 3'b100}); end
        OP = 1'b1; DST = 4'd7;
        tick();
        n_chk++;
        if (obs !== {8'h08, 8'h00, 8'h00, 3'b100}) begin n_fail++; $display("FAIL ign_capt: got %h want %h", obs, {8'h08, 8'h00, 8'h00, 3'b100}); end
        OP = 1'b0; SRC = 4'd2;
        tick();
        REQ = 1'b0;
        n_chk++;
        if (obs !== {8'h00, 8'h20, 8'h00, 3'b100}) begin n_fail++; $display("FAIL ign_write: got %h want %h", obs, {8'h00, 8'h20, 8'h00, 3'b100}); end
        n_chk++;
        if (BIN !== 16'h5A5A) begin n_fail++; $display("FAIL ign_bin: got %h want %h", BIN, 16'h5A5A); end
        tick(); tick();
        n_chk++;
        if (obs !== 27'd0) begin n_fail++; $display("FAIL ign_idle: got %h want %h", obs, 27'd0); end
        n_chk++;
        if ({regs[5], regs[6]} !== {16'h5A5A, 16'h0000}) begin n_fail++; $display("FAIL ign_regs: got %h want %h", {regs[5], regs[6]}, {16'h5A5A, 16'h0000}); end
    endtask

    task automatic test_reset_mid_move();
        regs[3] = 16'h1111; regs[5] = 16'h2222; regs[4] = 16'hBEEF; regs[0] = 16'h0000;
        issue(1'b0, 4'd3, 4'd5);
        tick();
        n_chk++;
        if (obs !== {8'h08, 8'h00, 8'h00, 3'b100}) begin n_fail++; $display("FAIL rst_mid_capt: got %h want %h", obs, {8'h08, 8'h00, 8'h00, 3'b100}); end
        RST = 1'b1;
        tick();
        n_chk++;
        if ({obs, BIN} !== 43'd0) begin n_fail++; $display("FAIL rst_mid_abort: got %h want %h", {obs, BIN}, 43'd0); end
        tick();
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (obs !== 27'd0) begin n_fail++; $display("FAIL rst_mid_quiet%0d: got %h want %h", c, obs, 27'd0); end
            tick();
        end
        n_chk++;
        if (regs[5] !== 16'h2222) begin n_fail++; $display("FAIL rst_mid_nowrite: got %h want %h", regs[5], 16'h2222); end
        issue(1'b0, 4'd4, 4'd0);
        tick(); tick();
        n_chk++;
        if (obs !== {8'h00, 8'h01, 8'h00, 3'b100}) begin n_fail++; $display("FAIL rst_new_write: got %h want %h", obs, {8'h00, 8'h01, 8'h00, 3'b100}); end
        tick();
        n_chk++;
        if (obs !== {8'h00, 8'h00, 8'h00, 3'b010}) begin n_fail++; $display("FAIL rst_new_done: got %h want %h", obs, {8'h00, 8'h00, 8'h00, 3'b010}); end
        n_chk++;
        if (regs[0] !== 16'hBEEF) begin n_fail++; $display("FAIL rst_new_val: got %h want %h", regs[0], 16'hBEEF); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < N_REGS; i++) regs[i] = 16'h0000;
        test_reset();
        test_move();
        test_increment();
        test_back_to_back();
        test_error();
        test_ignore_req();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
